// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control sequencer.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BEQ    = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic is_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mips_mc_next_state.sv
// Combinational next-state function of the multicycle control FSM.
module mips_mc_next_state
    import mips_mc_pkg::*;
(
    input  logic [3:0] state,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic [3:0] next_state
);

    state_t cur;
    state_t nxt;

    assign cur        = state_t'(state);
    assign next_state = nxt;

    always_comb begin
        nxt = FETCH;
        case (cur)
            FETCH:  nxt = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_RTYPE:     nxt = EXEC;
                    OP_BEQ:       nxt = BEQ;
                    OP_ADDI:      nxt = ADDIEX;
                    OP_J:         nxt = JUMP;
                    default:      nxt = FETCH;
                endcase
            end
            MEMADR: nxt = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  nxt = mem_ready ? MEMWB : MEMRD;
            MEMWB:  nxt = FETCH;
            MEMWR:  nxt = mem_ready ? FETCH : MEMWR;
            EXEC:   nxt = ALUWB;
            ALUWB:  nxt = FETCH;
            BEQ:    nxt = FETCH;
            ADDIEX: nxt = ADDIWB;
            ADDIWB: nxt = FETCH;
            JUMP:   nxt = FETCH;
            default: nxt = FETCH;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control unit: state register plus Moore output decode
// with memory-ready gating on the handshake-dependent strobes.
module mips_multicycle_control
    import mips_mc_pkg::*;
#(
    parameter int unsigned MEM_WAIT_EN = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t     state_r;
    logic [3:0] next_state;
    logic       ready;
    logic       pc_write;
    logic       branch;

    assign ready = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;
    assign state = state_r;

    mips_mc_next_state u_next_state (
        .state      (state_r),
        .opcode     (opcode),
        .mem_ready  (ready),
        .next_state (next_state)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_t'(next_state);
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        alu_op     = ALUOP_ADD;
        pc_source  = PCSRC_ALU;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        case (state_r)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = ready;
                pc_write  = ready;
            end
            DECODE: begin
                alu_src_b  = SRCB_IMM_SH;
                illegal_op = !is_supported(opcode);
            end
            MEMADR, ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            MEMWR: begin
                iord       = 1'b1;
                mem_write  = 1'b1;
                instr_done = ready;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            ALUWB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            BEQ: begin
                alu_src_a  = 1'b1;
                alu_op     = ALUOP_SUB;
                pc_source  = PCSRC_ALUOUT;
                branch     = 1'b1;
                instr_done = 1'b1;
            end
            ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            JUMP: begin
                pc_source  = PCSRC_JUMP;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase

        pc_en = pc_write | (branch & zero);

        // Reset suppresses every side effect so an aborted instruction leaves no trace.
        if (reset) begin
            pc_en      = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            instr_done = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench: per-instruction expected traces built from the
// instruction walk description and compared every cycle.
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;

    logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       instr_done, illegal_op;
    logic [3:0] state;

    logic       nw_pc_en, nw_iord, nw_mem_read, nw_mem_write, nw_ir_write, nw_reg_dst, nw_mem_to_reg;
    logic       nw_reg_write, nw_alu_src_a, nw_instr_done, nw_illegal_op;
    logic [1:0] nw_alu_src_b, nw_alu_op, nw_pc_source;
    logic [3:0] nw_state;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    mips_multicycle_control #(.MEM_WAIT_EN(1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
    );

    mips_multicycle_control #(.MEM_WAIT_EN(0)) dut_nw (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(1'b0),
        .pc_en(nw_pc_en), .iord(nw_iord), .mem_read(nw_mem_read), .mem_write(nw_mem_write),
        .ir_write(nw_ir_write), .reg_dst(nw_reg_dst), .mem_to_reg(nw_mem_to_reg),
        .reg_write(nw_reg_write), .alu_src_a(nw_alu_src_a), .alu_src_b(nw_alu_src_b),
        .alu_op(nw_alu_op), .pc_source(nw_pc_source), .instr_done(nw_instr_done),
        .illegal_op(nw_illegal_op), .state(nw_state)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
    } obs_t;

    typedef struct {
        obs_t o;
        logic rdy;
        logic z;
    } step_t;

    step_t q[$];

    function automatic obs_t sample();
        obs_t a;
        a = '{state, pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
              reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done, illegal_op};
        return a;
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic add(input obs_t o, input logic rdy, input logic z);
        step_t s;
        s.o = o;
        s.rdy = rdy;
        s.z = z;
        q.push_back(s);
    endtask

    // Expected per-cycle trace of one instruction: fw fetch waits, mw memory waits.
    task automatic build(input logic [5:0] op, input int unsigned fw, input int unsigned mw, input logic bz);
        obs_t o;
        logic legal;
        for (int unsigned i = 0; i <= fw; i++) begin
            o = '0;
            o.st = 4'd0;
            o.mem_read = 1'b1;
            o.alu_src_b = 2'b01;
            o.ir_write = (i == fw);
            o.pc_en = (i == fw);
            add(o, i == fw, rnd_bit());
        end
        legal = (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) ||
                (op == 6'h04) || (op == 6'h08) || (op == 6'h02);
        o = '0;
        o.st = 4'd1;
        o.alu_src_b = 2'b11;
        o.illegal_op = !legal;
        add(o, rnd_bit(), rnd_bit());
        if (!legal) return;
        case (op)
            6'h23, 6'h2B: begin
                o = '0; o.st = 4'd2; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
                add(o, rnd_bit(), rnd_bit());
                for (int unsigned i = 0; i <= mw; i++) begin
                    o = '0;
                    o.iord = 1'b1;
                    if (op == 6'h23) begin
                        o.st = 4'd3; o.mem_read = 1'b1;
                    end else begin
                        o.st = 4'd5; o.mem_write = 1'b1; o.instr_done = (i == mw);
                    end
                    add(o, i == mw, rnd_bit());
                end
                if (op == 6'h23) begin
                    o = '0; o.st = 4'd4; o.mem_to_reg = 1'b1; o.reg_write = 1'b1; o.instr_done = 1'b1;
                    add(o, rnd_bit(), rnd_bit());
                end
            end
            6'h00: begin
                o = '0; o.st = 4'd6; o.alu_src_a = 1'b1; o.alu_op = 2'b10;
                add(o, rnd_bit(), rnd_bit());
                o = '0; o.st = 4'd7; o.reg_dst = 1'b1; o.reg_write = 1'b1; o.instr_done = 1'b1;
                add(o, rnd_bit(), rnd_bit());
            end
            6'h04: begin
                o = '0; o.st = 4'd8; o.alu_src_a = 1'b1; o.alu_op = 2'b01; o.pc_source = 2'b01;
                o.instr_done = 1'b1; o.pc_en = bz;
                add(o, rnd_bit(), bz);
            end
            6'h08: begin
                o = '0; o.st = 4'd9; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
                add(o, rnd_bit(), rnd_bit());
                o = '0; o.st = 4'd10; o.reg_write = 1'b1; o.instr_done = 1'b1;
                add(o, rnd_bit(), rnd_bit());
            end
            default: begin
                o = '0; o.st = 4'd11; o.pc_source = 2'b10; o.pc_en = 1'b1; o.instr_done = 1'b1;
                add(o, rnd_bit(), rnd_bit());
            end
        endcase
    endtask

    task automatic run(input string name);
        step_t s;
        obs_t a;
        int cyc;
        cyc = 0;
        while (q.size() > 0) begin
            s = q.pop_front();
            mem_ready = s.rdy;
            zero = s.z;
            @(negedge clk);
            a = sample();
            compared++;
            if (a !== s.o) begin
                mismatched++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, a, s.o);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic do_instr(input string name, input logic [5:0] op, input int unsigned fw,
                            input int unsigned mw, input logic bz);
        opcode = op;
        build(op, fw, mw, bz);
        run(name);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_ready = 1'b1;
        zero = 1'b1;
        opcode = 6'h23;
        @(posedge clk);
        #1;
        @(negedge clk);
        compared++;
        if ({pc_en, ir_write, reg_write, mem_read, mem_write, instr_done, illegal_op} !== 7'b0) begin
            mismatched++;
            $display("FAIL reset_strobes: got %b expected 0000000",
                     {pc_en, ir_write, reg_write, mem_read, mem_write, instr_done, illegal_op});
        end
        compared++;
        if (state !== 4'd0 || nw_state !== 4'd0) begin
            mismatched++;
            $display("FAIL reset_state: got %0d/%0d expected 0/0", state, nw_state);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_rtype();
        do_instr("rtype", 6'h00, 0, 0, 1'b0);
    endtask

    task automatic test_lw_wait();
        do_instr("lw_wait", 6'h23, 0, 2, 1'b0);
    endtask

    task automatic test_beq();
        do_instr("beq_taken", 6'h04, 0, 0, 1'b1);
        do_instr("beq_not_taken", 6'h04, 0, 0, 1'b0);
    endtask

    task automatic test_fetch_stall();
        do_instr("fetch_stall", 6'h00, 3, 0, 1'b0);
    endtask

    task automatic test_illegal();
        do_instr("illegal", 6'h3F, 0, 0, 1'b0);
    endtask

    task automatic test_addi_j_sw();
        do_instr("addi", 6'h08, 1, 0, 1'b0);
        do_instr("jump", 6'h02, 0, 0, 1'b0);
        do_instr("sw_wait", 6'h2B, 0, 2, 1'b0);
    endtask

    task automatic test_no_wait();
        logic [3:0] seq [0:5];
        seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        reset = 1'b1;
        opcode = 6'h23;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            compared++;
            if (nw_state !== seq[i] || state !== 4'd0 || nw_instr_done !== (seq[i] == 4'd4)) begin
                mismatched++;
                $display("FAIL no_wait cycle %0d: got nw_state=%0d state=%0d done=%b expected %0d 0 %b",
                         i, nw_state, state, nw_instr_done, seq[i], seq[i] == 4'd4);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_sw_reset();
        opcode = 6'h2B;
        build(6'h2B, 0, 5, 1'b0);
        while (q.size() > 4) void'(q.pop_back());
        run("sw_reset_pre");
        mem_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        compared++;
        if (state !== 4'd5 || mem_write !== 1'b0 || instr_done !== 1'b0 || iord !== 1'b1) begin
            mismatched++;
            $display("FAIL sw_reset_cycle: got state=%0d mem_write=%b done=%b iord=%b expected 5 0 0 1",
                     state, mem_write, instr_done, iord);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        compared++;
        if (state !== 4'd0 || mem_write !== 1'b0 || instr_done !== 1'b0) begin
            mismatched++;
            $display("FAIL sw_reset_after: got state=%0d mem_write=%b done=%b expected 0 0 0",
                     state, mem_write, instr_done);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [0:5];
        logic [5:0] op;
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
            else op = ops[$urandom_range(0, 5)];
            do_instr("random", op, $urandom_range(0, 2), $urandom_range(0, 3), rnd_bit());
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_beq();
        test_fetch_stall();
        test_illegal();
        test_addi_j_sw();
        test_no_wait();
        test_sw_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
